// File: rtl/test_adder_pkg.sv
// Shared constants and result-packing helper for the registered ripple-carry adder.
package test_adder_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // Result layout is {cout, ovf, sum}; width depends on the instance parameter.
  function automatic int result_bits(input int width);
    return width + 2;
  endfunction

endpackage

// File: rtl/test_adder_full_adder.sv
// Single-bit full-adder cell, purely combinational; chained by test_adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/test_adder.sv
// Registered WIDTH-bit ripple-carry adder with carry-out, signed overflow and a
// one-cycle valid pipeline.
module test_adder
  import test_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid
);

  localparam int RES_W = result_bits(WIDTH);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_d;
  logic [RES_W-1:0] res_d;
  logic [RES_W-1:0] res_q;
  logic             valid_q;

  assign carry[0] = cin;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    full_adder u_fa (
      .a  (a[gi]),
      .b  (b[gi]),
      .ci (carry[gi]),
      .s  (sum_d[gi]),
      .co (carry[gi+1])
    );
  end

  // Signed overflow: carry into the MSB disagrees with carry out of it.
  assign res_d = {carry[WIDTH], carry[WIDTH-1] ^ carry[WIDTH], sum_d};

  // Result only loads on accepted input, so idle-cycle operand values never reach the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        res_q <= res_d;
      end
    end
  end

  assign cout      = res_q[RES_W-1];
  assign ovf       = res_q[RES_W-2];
  assign sum       = res_q[WIDTH-1:0];
  assign out_valid = valid_q;

endmodule

// File: tb/tb_test_adder.sv
// Directed, table-driven check of test_adder (WIDTH = 4) plus reset, hold and
// exhaustive back-to-back stream sequences.
module tb_test_adder;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         out_valid;

  int checks;
  int errors;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] exp_sum;
    logic       exp_cout;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs [10];

  test_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [3:0] es, input logic ec,
                         input logic eo, input logic ev);
    checks++;
    if (sum !== es || cout !== ec || ovf !== eo || out_valid !== ev) begin
      errors++;
      $display("FAIL %s: got sum=%0d cout=%0b ovf=%0b vld=%0b expected sum=%0d cout=%0b ovf=%0b vld=%0b",
               name, sum, cout, ovf, out_valid, es, ec, eo, ev);
    end else begin
      $display("ok   %s: sum=%0d cout=%0b ovf=%0b vld=%0b", name, sum, cout, ovf, out_valid);
    end
  endtask

  // Drive on the falling edge, then sample just after the next rising edge.
  task automatic step(input logic v, input logic [3:0] av, input logic [3:0] bv, input logic cv);
    @(negedge clk);
    in_valid = v;
    a        = av;
    b        = bv;
    cin      = cv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] full;
    logic       exp_ovf;

    checks = 0;
    errors = 0;

    vecs[0] = '{4'd3,  4'd5,  1'b0, 4'd8,  1'b0, 1'b1};
    vecs[1] = '{4'd15, 4'd1,  1'b0, 4'd0,  1'b1, 1'b0};
    vecs[2] = '{4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0};
    vecs[3] = '{4'd7,  4'd1,  1'b0, 4'd8,  1'b0, 1'b1};
    vecs[4] = '{4'd8,  4'd8,  1'b0, 4'd0,  1'b1, 1'b1};
    vecs[5] = '{4'd2,  4'd2,  1'b0, 4'd4,  1'b0, 1'b0};
    vecs[6] = '{4'd0,  4'd0,  1'b1, 4'd1,  1'b0, 1'b0};
    vecs[7] = '{4'd6,  4'd6,  1'b0, 4'd12, 1'b0, 1'b1};
    vecs[8] = '{4'd9,  4'd9,  1'b0, 4'd2,  1'b1, 1'b1};
    vecs[9] = '{4'd0,  4'd0,  1'b0, 4'd0,  1'b0, 1'b0};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_out("reset_state", 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      step(1'b1, vecs[i].a, vecs[i].b, vecs[i].cin);
      chk_out($sformatf("vec%0d %0d+%0d+%0d", i, vecs[i].a, vecs[i].b, vecs[i].cin),
              vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf, 1'b1);
    end

    // Hold: one valid 2+2, then idle cycles with different operands.
    step(1'b1, 4'd2, 4'd2, 1'b0);
    chk_out("hold_load", 4'd4, 1'b0, 1'b0, 1'b1);
    step(1'b0, 4'd9, 4'd9, 1'b0);
    chk_out("hold_idle1", 4'd4, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'd9, 4'd9, 1'b1);
    chk_out("hold_idle2", 4'd4, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-cycle with nonzero outputs.
    step(1'b1, 4'd15, 4'd15, 1'b1);
    chk_out("pre_reset", 4'd15, 1'b1, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_reset", 4'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_out("reset_held_edge", 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Exhaustive back-to-back stream; expected result computed arithmetically.
    for (int k = 0; k < 512; k++) begin
      logic [3:0] av;
      logic [3:0] bv;
      logic       cv;
      av = k[3:0];
      bv = k[7:4];
      cv = k[8];
      step(1'b1, av, bv, cv);
      full    = {1'b0, av} + {1'b0, bv} + {4'd0, cv};
      exp_ovf = (av[3] == bv[3]) && (full[3] != av[3]);
      chk($sformatf("stream %0d+%0d+%0d", av, bv, cv),
          {26'd0, out_valid, ovf, cout, sum}, {26'd0, 1'b1, exp_ovf, full[4], full[3:0]});
    end

    step(1'b0, 4'd1, 4'd1, 1'b0);
    chk("stream_end_valid", {31'd0, out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
